// File: rtl/scc_8lc_resp_stage.sv
// SCC 8LC response stage: 2-entry skid FIFO for decoded beats plus RAS telemetry
// (per-symbol corrected-error counters, DUE counter, sticky status flags).

module scc_8lc_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module scc_8lc_resp_stage #(
  parameter int CNT_W = 16,
  parameter int NSYM  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      dec_data,
  input  logic             dec_ok,
  input  logic [3:0]       dec_loc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_due,
  output logic             out_ce,
  output logic [3:0]       out_loc,
  input  logic             clr_cnt,
  input  logic [3:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_rd,
  output logic             due_sticky,
  output logic             loc_err_sticky
);
  typedef struct packed {
    logic [63:0] data;
    logic        due;
    logic        ce;
    logic [3:0]  loc;
  } ent_t;

  localparam ent_t ENT_RST = '{data: 64'h0, due: 1'b0, ce: 1'b0, loc: 4'hF};

  ent_t       mem_q [2];
  ent_t       mem_d [2];
  ent_t       ent_new;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic       due_sticky_q, due_sticky_d;
  logic       loc_err_sticky_q, loc_err_sticky_d;
  logic       acc, pop, loc_bad;

  logic [NSYM:0]            inc_vec;
  logic [NSYM:0][CNT_W-1:0] cnt_arr;

  // Ready and valid come only from registered occupancy.
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign ent_new.data = dec_data;
  assign ent_new.due  = ~dec_ok;
  assign ent_new.ce   = dec_ok & (dec_loc < 4'(NSYM));
  assign ent_new.loc  = dec_ok ? dec_loc : 4'hF;
  assign loc_bad      = dec_ok & (dec_loc >= 4'(NSYM)) & (dec_loc != 4'hF);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (acc) begin
      mem_d[wr_ptr_q] = ent_new;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    occ_d = occ_q + 2'(acc) - 2'(pop);
  end

  always_comb begin
    due_sticky_d     = due_sticky_q;
    loc_err_sticky_d = loc_err_sticky_q;
    if (clr_cnt) begin
      due_sticky_d     = 1'b0;
      loc_err_sticky_d = 1'b0;
    end else if (acc) begin
      if (ent_new.due) due_sticky_d     = 1'b1;
      if (loc_bad)     loc_err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]         <= ENT_RST;
      mem_q[1]         <= ENT_RST;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      occ_q            <= 2'd0;
      due_sticky_q     <= 1'b0;
      loc_err_sticky_q <= 1'b0;
    end else begin
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      occ_q            <= occ_d;
      due_sticky_q     <= due_sticky_d;
      loc_err_sticky_q <= loc_err_sticky_d;
    end
  end

  assign out_data       = mem_q[rd_ptr_q].data;
  assign out_due        = mem_q[rd_ptr_q].due;
  assign out_ce         = mem_q[rd_ptr_q].ce;
  assign out_loc        = mem_q[rd_ptr_q].loc;
  assign due_sticky     = due_sticky_q;
  assign loc_err_sticky = loc_err_sticky_q;

  // Slots 0..NSYM-1 are symbol CE counters, slot NSYM is the DUE counter.
  always_comb begin
    inc_vec = '0;
    for (int i = 0; i < NSYM; i++)
      inc_vec[i] = acc & ent_new.ce & (dec_loc == 4'(i));
    inc_vec[NSYM] = acc & ent_new.due;
  end

  for (genvar g = 0; g <= NSYM; g++) begin : g_cnt
    scc_8lc_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr_cnt),
      .inc  (inc_vec[g]),
      .cnt  (cnt_arr[g])
    );
  end

  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i <= NSYM; i++)
      if (cnt_sel == 4'(i)) cnt_rd = cnt_arr[i];
  end
endmodule

// File: tb/tb_scc_8lc_resp_stage.sv
// Bench for scc_8lc_resp_stage: directed vector table, hand sequences for
// saturation/clear/async reset, and random traffic against a queue-based model.

module tb_scc_8lc_resp_stage;
  localparam int CNT_W = 4;
  localparam int NSYM  = 10;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [63:0] dec_data = '0;
  logic dec_ok = 1'b1;
  logic [3:0] dec_loc = 4'hF;
  logic out_valid, out_ready = 1'b0;
  logic [63:0] out_data;
  logic out_due, out_ce;
  logic [3:0] out_loc;
  logic clr_cnt = 1'b0;
  logic [3:0] cnt_sel = 4'd0;
  logic [CNT_W-1:0] cnt_rd;
  logic due_sticky, loc_err_sticky;

  always #5 clk = ~clk;

  scc_8lc_resp_stage #(.CNT_W(CNT_W), .NSYM(NSYM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dec_data(dec_data), .dec_ok(dec_ok), .dec_loc(dec_loc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_due(out_due), .out_ce(out_ce), .out_loc(out_loc),
    .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .cnt_rd(cnt_rd),
    .due_sticky(due_sticky), .loc_err_sticky(loc_err_sticky)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] data;
    bit          due;
    bit          ce;
    logic [3:0]  loc;
  } m_ent_t;

  m_ent_t m_q[$];
  int     m_ce[NSYM];
  int     m_due;
  bit     m_dst, m_lst;

  task automatic m_reset();
    m_q.delete();
    foreach (m_ce[i]) m_ce[i] = 0;
    m_due = 0;
    m_dst = 0;
    m_lst = 0;
  endtask

  function automatic int m_cnt(input int sel);
    if (sel < NSYM) return m_ce[sel];
    if (sel == NSYM) return m_due;
    return 0;
  endfunction

  task automatic m_check();
    chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
    if (m_q.size() > 0) begin
      chk("out_data", out_data, m_q[0].data);
      chk("out_due", 64'(out_due), 64'(m_q[0].due));
      chk("out_ce", 64'(out_ce), 64'(m_q[0].ce));
      chk("out_loc", 64'(out_loc), 64'(m_q[0].loc));
    end
    chk("cnt_rd", 64'(cnt_rd), 64'(m_cnt(int'(cnt_sel))));
    chk("due_sticky", 64'(due_sticky), 64'(m_dst));
    chk("loc_err_sticky", 64'(loc_err_sticky), 64'(m_lst));
  endtask

  // Apply the current inputs to the model, then step the DUT across one edge.
  task automatic advance();
    bit acc, pop;
    m_ent_t e;
    acc = in_valid && (m_q.size() < 2);
    pop = out_ready && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      e.data = dec_data;
      e.due  = !dec_ok;
      e.ce   = dec_ok && (dec_loc <= 4'd9);
      e.loc  = dec_ok ? dec_loc : 4'hF;
      m_q.push_back(e);
    end
    if (clr_cnt) begin
      foreach (m_ce[i]) m_ce[i] = 0;
      m_due = 0;
      m_dst = 0;
      m_lst = 0;
    end else if (acc) begin
      if (!dec_ok) begin
        if (m_due < CMAX) m_due++;
        m_dst = 1;
      end else if (dec_loc <= 4'd9) begin
        if (m_ce[dec_loc] < CMAX) m_ce[dec_loc]++;
      end else if (dec_loc != 4'hF) begin
        m_lst = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic ok,
                       input logic [3:0] loc, input logic ordy, input logic clr,
                       input logic [3:0] sel);
    in_valid  = v;
    dec_data  = d;
    dec_ok    = ok;
    dec_loc   = loc;
    out_ready = ordy;
    clr_cnt   = clr;
    cnt_sel   = sel;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        ok;
    logic [3:0]  loc;
    logic        ordy;
    logic [3:0]  sel;
    logic        e_ov;
    logic        e_ir;
    logic [63:0] e_od;
    logic        e_due;
    logic        e_ce;
    logic [3:0]  e_loc;
    logic [3:0]  e_cnt;
    logic        e_dst;
    logic        e_lst;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [63:0] d, input logic ok, input logic [3:0] loc,
                     input logic ordy, input logic [3:0] sel, input logic e_ov, input logic e_ir,
                     input logic [63:0] e_od, input logic e_due, input logic e_ce,
                     input logic [3:0] e_loc, input logic [3:0] e_cnt, input logic e_dst,
                     input logic e_lst);
    vec_t t;
    t.v = v; t.d = d; t.ok = ok; t.loc = loc; t.ordy = ordy; t.sel = sel;
    t.e_ov = e_ov; t.e_ir = e_ir; t.e_od = e_od; t.e_due = e_due; t.e_ce = e_ce;
    t.e_loc = e_loc; t.e_cnt = e_cnt; t.e_dst = e_dst; t.e_lst = e_lst;
    tbl.push_back(t);
  endtask

  int  stall;
  logic [63:0] rdata;

  initial begin
    m_reset();
    // Clean stream, then a corrected symbol 9.
    add(1'b1, 64'h0,  1'b1, 4'hF, 1'b1, 4'd0,  1'b0, 1'b1, 64'h0,  1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0);
    add(1'b1, 64'h1,  1'b1, 4'hF, 1'b1, 4'd0,  1'b1, 1'b1, 64'h0,  1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0);
    add(1'b1, 64'h2,  1'b1, 4'hF, 1'b1, 4'd0,  1'b1, 1'b1, 64'h1,  1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0);
    add(1'b1, 64'h3,  1'b1, 4'hF, 1'b1, 4'd0,  1'b1, 1'b1, 64'h2,  1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0);
    add(1'b1, 64'h99, 1'b1, 4'd9, 1'b1, 4'd9,  1'b1, 1'b1, 64'h3,  1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0);
    add(1'b0, 64'h0,  1'b1, 4'hF, 1'b1, 4'd9,  1'b1, 1'b1, 64'h99, 1'b0, 1'b1, 4'd9, 4'd1, 1'b0, 1'b0);
    add(1'b0, 64'h0,  1'b1, 4'hF, 1'b1, 4'd3,  1'b0, 1'b1, 64'h0,  1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0);
    // DUE with backpressure: third beat stalls until a slot frees.
    add(1'b1, 64'hA1, 1'b1, 4'hF, 1'b0, 4'd10, 1'b0, 1'b1, 64'h0,  1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0);
    add(1'b1, 64'hA2, 1'b0, 4'd5, 1'b0, 4'd10, 1'b1, 1'b1, 64'hA1, 1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0);
    add(1'b1, 64'hA3, 1'b1, 4'hF, 1'b0, 4'd10, 1'b1, 1'b0, 64'hA1, 1'b0, 1'b0, 4'hF, 4'd1, 1'b1, 1'b0);
    add(1'b1, 64'hA3, 1'b1, 4'hF, 1'b0, 4'd10, 1'b1, 1'b0, 64'hA1, 1'b0, 1'b0, 4'hF, 4'd1, 1'b1, 1'b0);
    add(1'b1, 64'hA3, 1'b1, 4'hF, 1'b1, 4'd10, 1'b1, 1'b0, 64'hA1, 1'b0, 1'b0, 4'hF, 4'd1, 1'b1, 1'b0);
    add(1'b1, 64'hA3, 1'b1, 4'hF, 1'b1, 4'd10, 1'b1, 1'b1, 64'hA2, 1'b1, 1'b0, 4'hF, 4'd1, 1'b1, 1'b0);
    add(1'b0, 64'h0,  1'b1, 4'hF, 1'b1, 4'd10, 1'b1, 1'b1, 64'hA3, 1'b0, 1'b0, 4'hF, 4'd1, 1'b1, 1'b0);
    add(1'b0, 64'h0,  1'b1, 4'hF, 1'b1, 4'd10, 1'b0, 1'b1, 64'h0,  1'b0, 1'b0, 4'hF, 4'd1, 1'b1, 1'b0);
    // Illegal location 12: sticky only, no CE.
    add(1'b1, 64'hC0, 1'b1, 4'd12, 1'b1, 4'd10, 1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 4'hF, 4'd1, 1'b1, 1'b0);
    add(1'b0, 64'h0,  1'b1, 4'hF, 1'b1, 4'd10, 1'b1, 1'b1, 64'hC0, 1'b0, 1'b0, 4'd12, 4'd1, 1'b1, 1'b1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_data", out_data, 64'd0);
    chk("rst out_due", 64'(out_due), 64'd0);
    chk("rst out_ce", 64'(out_ce), 64'd0);
    chk("rst out_loc", 64'(out_loc), 64'hF);
    chk("rst due_sticky", 64'(due_sticky), 64'd0);
    chk("rst loc_err_sticky", 64'(loc_err_sticky), 64'd0);
    for (int s = 0; s < 16; s++) begin
      cnt_sel = 4'(s);
      #1;
      chk("rst cnt_rd", 64'(cnt_rd), 64'd0);
    end
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ok, tbl[i].loc, tbl[i].ordy, 1'b0, tbl[i].sel);
      #1;
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d out_data", i), out_data, tbl[i].e_od);
        chk($sformatf("vec%0d out_due", i), 64'(out_due), 64'(tbl[i].e_due));
        chk($sformatf("vec%0d out_ce", i), 64'(out_ce), 64'(tbl[i].e_ce));
        chk($sformatf("vec%0d out_loc", i), 64'(out_loc), 64'(tbl[i].e_loc));
      end
      chk($sformatf("vec%0d cnt_rd", i), 64'(cnt_rd), 64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d due_sticky", i), 64'(due_sticky), 64'(tbl[i].e_dst));
      chk($sformatf("vec%0d loc_err_sticky", i), 64'(loc_err_sticky), 64'(tbl[i].e_lst));
      m_check();
      advance();
    end

    // Saturation: 17 corrections at symbol 3 pin the counter at 15.
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 64'(k), 1'b1, 4'd3, 1'b1, 1'b0, 4'd3);
      #1;
      m_check();
      advance();
    end
    drive(1'b0, 64'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'd3);
    #1;
    chk("sat ce_cnt3", 64'(cnt_rd), 64'd15);
    m_check();
    // Clear with a concurrent symbol-3 correction.
    drive(1'b1, 64'hBEEF, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3);
    #1;
    advance();
    drive(1'b0, 64'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'd3);
    #1;
    chk("clr ce_cnt3", 64'(cnt_rd), 64'd0);
    chk("clr due_sticky", 64'(due_sticky), 64'd0);
    chk("clr loc_err_sticky", 64'(loc_err_sticky), 64'd0);
    m_check();
    advance();

    // Hold stability under backpressure, bounded wait for a full FIFO.
    drive(1'b1, 64'h5A5A, 1'b0, 4'd1, 1'b0, 1'b0, 4'd10);
    #1;
    advance();
    drive(1'b1, 64'h6B6B, 1'b1, 4'd2, 1'b0, 1'b0, 4'd10);
    #1;
    advance();
    stall = 0;
    while (in_ready && stall < 20) begin
      advance();
      stall++;
    end
    chk("full in_ready", 64'(in_ready), 64'd0);
    rdata = out_data;
    drive(1'b0, 64'h0, 1'b1, 4'hF, 1'b0, 1'b0, 4'd10);
    #1;
    m_check();
    advance();
    chk("hold out_data", out_data, rdata);
    chk("hold due_cnt", 64'(cnt_rd), 64'd1);

    // Async reset with two entries buffered takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst due_cnt", 64'(cnt_rd), 64'd0);
    chk("arst due_sticky", 64'(due_sticky), 64'd0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    m_check();

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 3) != 0),
            {$urandom, $urandom},
            1'($urandom_range(0, 7) != 0),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0),
            4'($urandom_range(0, 15)));
      #1;
      m_check();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scc_8lc_resp_stage.md
# scc_8lc_resp_stage

Registered response stage directly downstream of the SCC 8LC combinational decoder. It captures each decoded beat (64-bit data, decode status, error symbol location) through a valid/ready handshake into a 2-entry skid FIFO and presents it to the memory-controller read-return path. It also keeps per-symbol corrected-error counters, a DUE counter and sticky status flags for RAS telemetry.

## Interface
Parameters:
- CNT_W, 16, width of each saturating error counter
- NSYM, 10, number of codeword symbols (8 data + 2 check, 8 bits each)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoder beat valid
- in_ready  out  1  stage can accept a beat
- dec_data  in  64  corrected data from decoder
- dec_ok  in  1  1 = clean or corrected; 0 = detected uncorrectable (DUE)
- dec_loc  in  4  corrected symbol index 0..9; 4'hF = no error; ignored when dec_ok=0
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_data  out  64  data of head entry
- out_due  out  1  head entry is DUE
- out_ce  out  1  head entry had a corrected symbol
- out_loc  out  4  dec_loc of head entry (4'hF if none or DUE)
- clr_cnt  in  1  synchronous clear of all counters and sticky flags
- cnt_sel  in  4  counter select: 0..9 symbol CE counters, 10 = DUE counter, others read 0
- cnt_rd  out  CNT_W  selected counter value (combinational mux of registers)
- due_sticky  out  1  set on any accepted DUE
- loc_err_sticky  out  1  set on accepted beat with dec_ok=1 and dec_loc in 10..14

## Operation
- Accept = in_valid & in_ready; pop = out_valid & out_ready.
- FIFO: 2 entries, each {data, due, ce, loc}; occupancy counter 0..2; wr/rd pointers wrap 1->0.
- Entry encoding at accept: due = ~dec_ok; ce = dec_ok & (dec_loc <= 9); loc = due ? 4'hF : dec_loc.
- Counters update only on accept: ce -> ce_cnt[dec_loc]+1; due -> due_cnt+1; dec_ok & loc 10..14 -> loc_err_sticky=1, no counter change.
- Counters saturate at 2^CNT_W-1, never wrap.
- clr_cnt has priority over a same-cycle increment: counter ends at 0, sticky flags end at 0.
- Data and status pass through unmodified; no reordering.

## Timing
- Reset (async assert, sync-style deassert to clk): occupancy 0, pointers 0, out_valid=0, in_ready=1, out_data=0, out_due=0, out_ce=0, out_loc=4'hF, all counters 0, both stickies 0.
- in_ready = (occupancy < 2), registered-state derived; does not depend on out_ready (no combinational ready path).
- Latency: beat accepted in cycle N appears at out_* in cycle N+1 if FIFO was empty.
- Occupancy 1, simultaneous accept and pop: occupancy stays 1, new beat becomes head next cycle.
- Occupancy 2: in_ready=0; pop frees slot, in_ready=1 next cycle.
- Occupancy 0: out_valid=0; out_ready ignored, no underflow.
- out_* hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation drops all buffered entries; no partial beat emerges.
- Sustained throughput: 1 beat/cycle with out_ready held 1.

## Test plan
- Clean stream: 4 beats dec_ok=1, dec_loc=F, data=0x0..03, out_ready=1 -> same data 1 cycle later in order, out_ce=0, all counters 0.
- Corrected symbol: dec_ok=1, dec_loc=9 -> out_ce=1, out_loc=9; cnt_sel=9 reads 1, others 0.
- DUE + backpressure: out_ready=0, push 3 beats (2nd with dec_ok=0) -> in_ready=0 after 2 accepts, 3rd stalls; release -> order kept, 2nd out_due=1, out_loc=F, cnt_sel=10 reads 1, due_sticky=1.
- Saturation and clear: CNT_W=4, 17 beats dec_loc=3 -> ce_cnt[3]=15; clr_cnt with a concurrent loc=3 accept -> reads 0.
- Illegal location: dec_ok=1, dec_loc=12 -> loc_err_sticky=1, out_ce=0, no counter change.
- Async reset with occupancy 2 -> out_valid=0, in_ready=1, counters 0 immediately.
